bank_replica_loader: RTL and testbench

BANK_REPLICA_LOADER -- requirements
Module: bank_replica_loader

---
 rtl/po_fpga_pkg.sv | 34 +++
 rtl/bank_compare.sv | 19 +
 rtl/bank_replica_loader.sv | 162 ++++++++++++++++
 tb/tb_bank_replica_loader.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/po_fpga_pkg.sv
// Shared operation-mode and FSM state encodings for the bank replica loader.
package po_fpga_pkg;

    typedef enum logic [1:0] {
        MODE_LOAD  = 2'd0,
        MODE_DUMP  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DUMP_RD,
        ST_DUMP_OUT,
        ST_CHECK_RD,
        ST_CHECK_CMP,
        ST_DONE
    } state_e;

    // The reserved encoding behaves exactly like CHECK.
    function automatic logic mode_is_check(mode_e m);
        return (m == MODE_CHECK) || (m == MODE_RSVD);
    endfunction

    function automatic state_e first_state(mode_e m);
        case (m)
            MODE_LOAD: return ST_LOAD;
            MODE_DUMP: return ST_DUMP_RD;
            default:   return ST_CHECK_RD;
        endcase
    endfunction

endpackage

// File: rtl/bank_compare.sv
// Combinational replica comparator: all_equal is high when every bank word matches bank 0.
module bank_compare #(
    parameter int DATA_W    = 64,
    parameter int NUM_BANKS = 6
) (
    input  logic [NUM_BANKS*DATA_W-1:0] rdata,
    output logic                        all_equal
);

    always_comb begin
        all_equal = 1'b1;
        for (int unsigned k = 1; k < NUM_BANKS; k++) begin
            if (rdata[k*DATA_W +: DATA_W] != rdata[DATA_W-1:0]) begin
                all_equal = 1'b0;
            end
        end
    end

endmodule

// File: rtl/bank_replica_loader.sv
// Loads, dumps and cross-checks a set of externally held replicated banks
// through a broadcast write port and a common 1-cycle-latency read port.
module bank_replica_loader
    import po_fpga_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int DEPTH     = 256,
    parameter int NUM_BANKS = 6,
    parameter int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        go_i,
    input  logic [1:0]                  mode_i,
    input  logic [ADDR_W:0]             len_i,
    input  logic                        s_valid,
    input  logic [DATA_W-1:0]           s_data,
    output logic                        s_ready,
    output logic                        m_valid,
    output logic [DATA_W-1:0]           m_data,
    output logic [ADDR_W-1:0]           m_addr,
    input  logic                        m_ready,
    output logic                        bank_we,
    output logic [ADDR_W-1:0]           bank_waddr,
    output logic [DATA_W-1:0]           bank_wdata,
    output logic [ADDR_W-1:0]           bank_raddr,
    input  logic [NUM_BANKS*DATA_W-1:0] bank_rdata,
    output logic                        busy,
    output logic                        done,
    output logic                        mismatch,
    output logic [ADDR_W-1:0]           mismatch_addr
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic                mismatch_q, mismatch_d;
    logic [ADDR_W-1:0]   mm_addr_q, mm_addr_d;
    logic [DATA_W-1:0]   m_data_q, m_data_d;
    logic                held_q, held_d;
    logic [ADDR_W:0]     cnt_inc;
    logic [ADDR_W:0]     len_clamp;
    logic                last;
    logic                all_equal;

    bank_compare #(
        .DATA_W    (DATA_W),
        .NUM_BANKS (NUM_BANKS)
    ) u_cmp (
        .rdata     (bank_rdata),
        .all_equal (all_equal)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        mismatch_d = mismatch_q;
        mm_addr_d  = mm_addr_q;
        m_data_d   = m_data_q;
        held_d     = held_q;
        cnt_inc    = {1'b0, cnt_q} + {{ADDR_W{1'b0}}, 1'b1};
        last       = (cnt_inc == len_q);
        len_clamp  = (len_i > DEPTH_L) ? DEPTH_L : len_i;

        case (state_q)
            ST_IDLE: begin
                if (go_i) begin
                    cnt_d  = '0;
                    len_d  = len_clamp;
                    held_d = 1'b0;
                    if (mode_is_check(mode_e'(mode_i))) begin
                        mismatch_d = 1'b0;
                    end
                    state_d = (len_clamp == '0) ? ST_DONE : first_state(mode_e'(mode_i));
                end
            end
            ST_LOAD: begin
                if (s_valid) begin
                    if (last) state_d = ST_DONE;
                    else      cnt_d   = cnt_inc[ADDR_W-1:0];
                end
            end
            ST_DUMP_RD: begin
                held_d  = 1'b0;
                state_d = ST_DUMP_OUT;
            end
            ST_DUMP_OUT: begin
                // Read data is only valid in the first OUT cycle; capture it there and hold.
                if (!held_q) begin
                    m_data_d = bank_rdata[DATA_W-1:0];
                    held_d   = 1'b1;
                end
                if (m_ready) begin
                    if (last) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = cnt_inc[ADDR_W-1:0];
                        state_d = ST_DUMP_RD;
                    end
                end
            end
            ST_CHECK_RD: begin
                state_d = ST_CHECK_CMP;
            end
            ST_CHECK_CMP: begin
                if (!all_equal && !mismatch_q) begin
                    mismatch_d = 1'b1;
                    mm_addr_d  = cnt_q;
                end
                if (last) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_inc[ADDR_W-1:0];
                    state_d = ST_CHECK_RD;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            mismatch_q <= 1'b0;
            mm_addr_q  <= '0;
            m_data_q   <= '0;
            held_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            mismatch_q <= mismatch_d;
            mm_addr_q  <= mm_addr_d;
            m_data_q   <= m_data_d;
            held_q     <= held_d;
        end
    end

    assign s_ready       = (state_q == ST_LOAD);
    assign bank_we       = s_ready && s_valid;
    assign bank_waddr    = cnt_q;
    assign bank_wdata    = s_data;
    assign bank_raddr    = cnt_q;
    assign m_valid       = (state_q == ST_DUMP_OUT);
    assign m_data        = (m_valid && !held_q) ? bank_rdata[DATA_W-1:0] : m_data_q;
    assign m_addr        = cnt_q;
    assign busy          = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done          = (state_q == ST_DONE);
    assign mismatch      = mismatch_q;
    assign mismatch_addr = mm_addr_q;

endmodule

// File: tb/tb_bank_replica_loader.sv
// Randomised self-checking bench for bank_replica_loader with an external bank model.
module tb_bank_replica_loader;
    import po_fpga_pkg::*;

    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int NB    = 4;
    localparam int AW    = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              go_i;
    logic [1:0]        mode_i;
    logic [AW:0]       len_i;
    logic              s_valid;
    logic [DW-1:0]     s_data;
    logic              s_ready;
    logic              m_valid;
    logic [DW-1:0]     m_data;
    logic [AW-1:0]     m_addr;
    logic              m_ready;
    logic              bank_we;
    logic [AW-1:0]     bank_waddr;
    logic [DW-1:0]     bank_wdata;
    logic [AW-1:0]     bank_raddr;
    logic [NB*DW-1:0]  bank_rdata;
    logic              busy;
    logic              done;
    logic              mismatch;
    logic [AW-1:0]     mismatch_addr;

    bank_replica_loader #(
        .DATA_W    (DW),
        .DEPTH     (DEPTH),
        .NUM_BANKS (NB),
        .ADDR_W    (AW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .go_i          (go_i),
        .mode_i        (mode_i),
        .len_i         (len_i),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .s_ready       (s_ready),
        .m_valid       (m_valid),
        .m_data        (m_data),
        .m_addr        (m_addr),
        .m_ready       (m_ready),
        .bank_we       (bank_we),
        .bank_waddr    (bank_waddr),
        .bank_wdata    (bank_wdata),
        .bank_raddr    (bank_raddr),
        .bank_rdata    (bank_rdata),
        .busy          (busy),
        .done          (done),
        .mismatch      (mismatch),
        .mismatch_addr (mismatch_addr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // External banks: broadcast write, registered read; tb_we lets the bench preload/corrupt.
    logic [DW-1:0] mem [NB][DEPTH];
    logic          tb_we = 1'b0;
    logic [AW-1:0] tb_addr = '0;
    logic [DW-1:0] tb_row [NB];

    always @(posedge clk) begin
        for (int k = 0; k < NB; k++) begin
            if (tb_we) mem[k][tb_addr] <= tb_row[k];
            else if (bank_we) mem[k][bank_waddr] <= bank_wdata;
            bank_rdata[k*DW +: DW] <= mem[k][bank_raddr];
        end
    end

    typedef struct { int addr; int data; int cyc; } ev_t;
    ev_t wr_q[$];
    ev_t dm_q[$];

    always @(negedge clk) begin
        if (!reset) begin
            if (bank_we) wr_q.push_back('{int'(bank_waddr), int'(bank_wdata), cyc});
            if (m_valid && m_ready) dm_q.push_back('{int'(m_addr), int'(m_data), cyc});
        end
    end

    int checks = 0;
    int failures = 0;
    logic [DW-1:0] words [DEPTH+8];
    bit got_done;
    bit done_after;
    int go_cyc, done_cyc, stall_obs, stall_bad;
    bit mismatch_ref;

    function automatic int clampf(int l);
        return (l > DEPTH) ? DEPTH : l;
    endfunction

    function automatic int first_bad(int n);
        for (int i = 0; i < n; i++)
            for (int k = 1; k < NB; k++)
                if (mem[k][i] !== mem[0][i]) return i;
        return -1;
    endfunction

    task automatic set_row(input int a, input logic [DW-1:0] v, input int bad_bank, input logic [DW-1:0] bad_v);
        @(posedge clk); #1;
        tb_we = 1'b1;
        tb_addr = AW'(a);
        for (int k = 0; k < NB; k++) tb_row[k] = (k == bad_bank) ? bad_v : v;
        @(posedge clk); #1;
        tb_we = 1'b0;
    endtask

    // Stimulus driver only: issues one operation and plays both stream sides until done.
    task automatic run_op(input logic [1:0] md, input int len, input bit gaps,
                          input int stall_addr, input int stall_len, input bit pulse_go);
        int widx, stalled;
        wr_q.delete();
        dm_q.delete();
        widx = 0; stalled = 0; stall_obs = 0; stall_bad = 0; got_done = 0; done_cyc = -1;
        @(posedge clk); #1;
        go_i = 1'b1; mode_i = md; len_i = (AW+1)'(len); s_valid = 1'b0; m_ready = 1'b0;
        go_cyc = cyc;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            go_i = pulse_go && (c == 4);
            if (go_i) begin mode_i = MODE_LOAD; len_i = 3; end
            s_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_data  = words[(widx < DEPTH+8) ? widx : 0];
            if (m_valid && stall_addr >= 0 && int'(m_addr) == stall_addr && stalled < stall_len) begin
                m_ready = 1'b0;
                stalled++;
            end else begin
                m_ready = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            @(negedge clk);
            if (s_valid && s_ready) widx++;
            if (m_valid && !m_ready) begin
                stall_obs++;
                if (int'(m_addr) != dm_q.size() || m_data !== mem[0][m_addr]) stall_bad++;
            end
            if (done) begin got_done = 1; done_cyc = cyc; break; end
        end
        @(posedge clk); #1;
        go_i = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        @(negedge clk);
        done_after = done;
    endtask

    task automatic test_reset;
        checks++;
        if ({busy, done, s_ready, m_valid, bank_we, mismatch} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=000000", {busy, done, s_ready, m_valid, bank_we, mismatch});
        end
        checks++;
        if (mismatch_addr !== '0) begin failures++; $display("FAIL reset_mm_addr got=%0h exp=0", mismatch_addr); end
        checks++;
        if (m_data !== '0) begin failures++; $display("FAIL reset_m_data got=%0h exp=0", m_data); end
    endtask

    task automatic test_load_basic;
        for (int i = 0; i < 11; i++) words[i] = DW'(16'h10 + i);
        run_op(MODE_LOAD, 11, 0, -1, 0, 0);
        checks++;
        if (!got_done || done_cyc != go_cyc + 12) begin
            failures++; $display("FAIL load_done_cycle got=%0d exp=%0d", done_cyc - go_cyc, 12);
        end
        checks++;
        if (wr_q.size() != 11) begin failures++; $display("FAIL load_count got=%0d exp=11", wr_q.size()); end
        for (int i = 0; i < wr_q.size() && i < 11; i++) begin
            checks++;
            if (wr_q[i].addr != i || wr_q[i].data != 16'h10 + i || wr_q[i].cyc != go_cyc + 1 + i) begin
                failures++;
                $display("FAIL load_word%0d got=a%0d d%0h c%0d exp=a%0d d%0h c%0d", i, wr_q[i].addr,
                         wr_q[i].data, wr_q[i].cyc - go_cyc, i, 16'h10 + i, 1 + i);
            end
        end
        checks++;
        if (done_after !== 1'b0) begin failures++; $display("FAIL load_done_width got=%b exp=0", done_after); end
    endtask

    task automatic test_dump_stall;
        for (int i = 0; i < 4; i++) set_row(i, DW'(16'hA0 + i), -1, '0);
        run_op(MODE_DUMP, 4, 0, 2, 3, 0);
        checks++;
        if (!got_done || done_cyc != go_cyc + 12) begin
            failures++; $display("FAIL dump_done_cycle got=%0d exp=12", done_cyc - go_cyc);
        end
        checks++;
        if (dm_q.size() != 4) begin failures++; $display("FAIL dump_count got=%0d exp=4", dm_q.size()); end
        for (int i = 0; i < dm_q.size() && i < 4; i++) begin
            checks++;
            if (dm_q[i].addr != i || dm_q[i].data != 16'hA0 + i) begin
                failures++;
                $display("FAIL dump_word%0d got=a%0d d%0h exp=a%0d d%0h", i, dm_q[i].addr, dm_q[i].data, i, 16'hA0 + i);
            end
        end
        checks++;
        if (stall_obs != 3 || stall_bad != 0) begin
            failures++; $display("FAIL dump_stall got=obs%0d bad%0d exp=obs3 bad0", stall_obs, stall_bad);
        end
        checks++;
        if (wr_q.size() != 0) begin failures++; $display("FAIL dump_no_write got=%0d exp=0", wr_q.size()); end
    endtask

    task automatic test_check_corrupt;
        logic [DW-1:0] v;
        int fb;
        for (int i = 0; i < 8; i++) begin
            v = DW'($urandom);
            set_row(i, v, (i == 5 || i == 6) ? 3 : -1, ~v);
        end
        fb = first_bad(8);
        run_op(MODE_CHECK, 8, 0, -1, 0, 0);
        mismatch_ref = (fb >= 0);
        checks++;
        if (!got_done || done_cyc != go_cyc + 17) begin
            failures++; $display("FAIL check_done_cycle got=%0d exp=17", done_cyc - go_cyc);
        end
        checks++;
        if (mismatch !== 1'b1 || int'(mismatch_addr) != 5 || fb != 5) begin
            failures++; $display("FAIL check_mismatch got=%b@%0d exp=1@5", mismatch, mismatch_addr);
        end
        checks++;
        if (wr_q.size() != 0 || dm_q.size() != 0) begin
            failures++; $display("FAIL check_no_stream got=w%0d d%0d exp=w0 d0", wr_q.size(), dm_q.size());
        end
    endtask

    task automatic test_mismatch_sticky;
        run_op(MODE_DUMP, 2, 0, -1, 0, 0);
        checks++;
        if (mismatch !== 1'b1 || mismatch_addr !== AW'(5)) begin
            failures++; $display("FAIL sticky_after_dump got=%b@%0d exp=1@5", mismatch, mismatch_addr);
        end
        set_row(5, mem[0][5], -1, '0);
        set_row(6, mem[0][6], -1, '0);
        run_op(MODE_RSVD, 8, 0, -1, 0, 0);
        mismatch_ref = 1'b0;
        checks++;
        if (mismatch !== 1'b0 || !got_done) begin
            failures++; $display("FAIL sticky_clear_by_check got=%b exp=0", mismatch);
        end
    endtask

    task automatic test_len_zero;
        for (int m = 0; m < 4; m++) begin
            run_op(2'(m), 0, 0, -1, 0, 0);
            checks++;
            if (!got_done || done_cyc != go_cyc + 1 || wr_q.size() != 0 || dm_q.size() != 0 || done_after !== 1'b0) begin
                failures++;
                $display("FAIL len0_mode%0d got=dc%0d w%0d d%0d exp=dc1 w0 d0", m, done_cyc - go_cyc, wr_q.size(), dm_q.size());
            end
            if (m >= 2) mismatch_ref = 1'b0;
        end
    endtask

    task automatic test_clamp;
        int bad;
        for (int i = 0; i < DEPTH+8; i++) words[i] = DW'($urandom);
        run_op(MODE_LOAD, DEPTH + 5, 0, -1, 0, 0);
        bad = 0;
        for (int i = 0; i < wr_q.size(); i++)
            if (wr_q[i].addr != i || wr_q[i].data != int'(words[i])) bad++;
        checks++;
        if (!got_done || wr_q.size() != DEPTH || bad != 0) begin
            failures++; $display("FAIL clamp_load got=n%0d bad%0d exp=n%0d bad0", wr_q.size(), bad, DEPTH);
        end
        run_op(MODE_DUMP, DEPTH + 5, 1, -1, 0, 0);
        bad = 0;
        for (int i = 0; i < dm_q.size(); i++)
            if (dm_q[i].addr != i || dm_q[i].data != int'(words[i])) bad++;
        checks++;
        if (!got_done || dm_q.size() != DEPTH || bad != 0 || stall_bad != 0) begin
            failures++;
            $display("FAIL clamp_dump got=n%0d bad%0d stall%0d exp=n%0d bad0 stall0", dm_q.size(), bad, stall_bad, DEPTH);
        end
    endtask

    task automatic test_go_ignored;
        run_op(MODE_DUMP, 6, 0, -1, 0, 1);
        checks++;
        if (!got_done || dm_q.size() != 6 || wr_q.size() != 0 || done_cyc != go_cyc + 13) begin
            failures++;
            $display("FAIL go_ignored got=d%0d w%0d dc%0d exp=d6 w0 dc13", dm_q.size(), wr_q.size(), done_cyc - go_cyc);
        end
    endtask

    task automatic test_reset_abort;
        int widx;
        bit hit;
        for (int i = 0; i < 10; i++) words[i] = DW'(16'h30 + i);
        widx = 0; hit = 0;
        @(posedge clk); #1;
        go_i = 1'b1; mode_i = MODE_LOAD; len_i = 10; s_valid = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            go_i = 1'b0; s_valid = 1'b1; s_data = words[widx];
            @(negedge clk);
            if (s_valid && s_ready) begin
                if (widx == 3) begin hit = 1; break; end
                widx++;
            end
        end
        checks++;
        if (!hit) begin failures++; $display("FAIL reset_abort_reach got=%0d exp=3", widx); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, s_ready, m_valid, bank_we, mismatch} !== 6'b0 || m_data !== '0 || mismatch_addr !== '0) begin
            failures++;
            $display("FAIL reset_abort_outputs got=%b md%0h ma%0h exp=000000 md0 ma0",
                     {busy, done, s_ready, m_valid, bank_we, mismatch}, m_data, mismatch_addr);
        end
        s_valid = 1'b0;
        mismatch_ref = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        words[0] = 16'h5A5A; words[1] = 16'hC3C3;
        run_op(MODE_LOAD, 2, 0, -1, 0, 0);
        checks++;
        if (!got_done || wr_q.size() != 2 || done_cyc != go_cyc + 3) begin
            failures++; $display("FAIL reset_reload got=n%0d dc%0d exp=n2 dc3", wr_q.size(), done_cyc - go_cyc);
        end
        else begin
            checks++;
            if (wr_q[0].addr != 0 || wr_q[0].data != 16'h5A5A || wr_q[1].addr != 1 || wr_q[1].data != 16'hC3C3) begin
                failures++;
                $display("FAIL reset_reload_data got=%0d:%0h %0d:%0h exp=0:5a5a 1:c3c3",
                         wr_q[0].addr, wr_q[0].data, wr_q[1].addr, wr_q[1].data);
            end
        end
    endtask

    task automatic test_random;
        int md, len, n, bad, fb;
        logic [DW-1:0] exp_d [DEPTH];
        for (int op = 0; op < 14; op++) begin
            md  = $urandom_range(0, 3);
            len = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, DEPTH + 3);
            n   = clampf(len);
            for (int i = 0; i < DEPTH+8; i++) words[i] = DW'($urandom);
            if (md >= 2 && $urandom_range(0, 1) == 1) begin
                int a;
                a = $urandom_range(0, DEPTH - 1);
                set_row(a, mem[0][a], $urandom_range(1, NB - 1), ~mem[0][a]);
            end
            for (int i = 0; i < DEPTH; i++) exp_d[i] = mem[0][i];
            fb = first_bad(n);
            run_op(2'(md), len, 1, -1, 0, 0);
            bad = 0;
            if (md == 0) begin
                if (wr_q.size() != n || dm_q.size() != 0) bad++;
                for (int i = 0; i < wr_q.size(); i++)
                    if (wr_q[i].addr != i || wr_q[i].data != int'(words[i])) bad++;
            end else if (md == 1) begin
                if (dm_q.size() != n || wr_q.size() != 0 || stall_bad != 0) bad++;
                for (int i = 0; i < dm_q.size(); i++)
                    if (dm_q[i].addr != i || dm_q[i].data != int'(exp_d[i])) bad++;
            end else begin
                mismatch_ref = (fb >= 0);
                if (wr_q.size() != 0 || dm_q.size() != 0) bad++;
                if (fb >= 0 && int'(mismatch_addr) != fb) bad++;
            end
            checks++;
            if (!got_done || done_after !== 1'b0 || mismatch !== mismatch_ref || bad != 0) begin
                failures++;
                $display("FAIL random_op%0d mode%0d len%0d got=done%0d mm%b bad%0d exp=done1 mm%b bad0",
                         op, md, len, got_done, mismatch, bad, mismatch_ref);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        go_i = 1'b0; mode_i = '0; len_i = '0;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        for (int k = 0; k < NB; k++) tb_row[k] = '0;
        mismatch_ref = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int a = 0; a < DEPTH; a++) set_row(a, DW'($urandom), -1, '0);
        test_load_basic();
        test_dump_stall();
        test_check_corrupt();
        test_mismatch_sticky();
        test_len_zero();
        test_clamp();
        test_go_ignored();
        test_reset_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
